pll_reset_sequencer: RTL

Supervisor for the system PLL: drives the PLL reset, qualifies `locked`, times out and retries failed lock attempts, and releases per-domain reset requests in a fixed staggered order. On lock loss it re-asserts every domain reset and restarts the sequence. The block runs on the PLL reference clock and sits between the PLL wrapper and the per-domain reset synchronizers, which live in each output-clock domain.

---
 rtl/pll_seq_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/pll_reset_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types, default parameters and counter sizing for the PLL reset sequencer.
// Pure declarations: no latency, no backpressure.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_e;

    localparam int DEF_RST_PULSE_CYCLES    = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 256;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 1_000_000;
    localparam int DEF_MAX_RETRIES         = 7;
    localparam int DEF_NUM_DOMAINS         = 5;
    localparam int DEF_STAGGER_CYCLES      = 64;

    // One spare bit over $clog2 so a counter can always hold its terminal value.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, synchronous reset to 0.
// Latency 2 cycles; no backpressure.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: pulses PLL reset, qualifies lock with timeout/retry, staggers domain reset release.
// Lock-to-release latency 2 + LOCK_STABLE_CYCLES + 1 cycles; no backpressure, all outputs registered.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int NUM_DOMAINS         = DEF_NUM_DOMAINS,
    parameter int STAGGER_CYCLES      = DEF_STAGGER_CYCLES
) (
    input  logic                   i_refclk,
    input  logic                   i_rst,
    input  logic                   i_pll_locked,
    input  logic                   i_restart_req,
    output logic                   o_pll_rst,
    output logic [NUM_DOMAINS-1:0] o_dom_rst,
    output logic                   o_ready,
    output logic                   o_fault,
    output logic [7:0]             o_retry_count,
    output logic [7:0]             o_lock_loss_count
);

    localparam int PULSE_W  = cnt_width(RST_PULSE_CYCLES);
    localparam int STABLE_W = cnt_width(LOCK_STABLE_CYCLES);
    localparam int TMO_W    = cnt_width(LOCK_TIMEOUT_CYCLES);
    localparam int REL_MAX  = (NUM_DOMAINS - 1) * STAGGER_CYCLES + 1;
    localparam int REL_W    = cnt_width(REL_MAX);

    localparam logic [PULSE_W-1:0]  PULSE_LAST  = PULSE_W'(RST_PULSE_CYCLES - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [8:0]          RETRY_LIMIT = 9'(MAX_RETRIES);

    state_e                  r_state;
    logic                    r_pll_rst;
    logic [NUM_DOMAINS-1:0]  r_dom_rst;
    logic                    r_ready;
    logic                    r_fault;
    logic [7:0]              r_retry_cnt;
    logic [7:0]              r_loss_cnt;
    logic [PULSE_W-1:0]      r_pulse_cnt;
    logic [STABLE_W-1:0]     r_stable_cnt;
    logic [TMO_W-1:0]        r_tmo_cnt;
    logic [REL_W-1:0]        r_rel_cnt;

    logic                    w_lock_s;
    logic                    w_tmo_hit;
    logic                    w_stable_hit;
    logic [8:0]              w_retry_next;
    logic [7:0]              w_retry_sat;
    logic [7:0]              w_loss_next;
    logic [NUM_DOMAINS-1:0]  w_rel_mask;

    sync_2ff u_lock_sync (
        .i_clk (i_refclk),
        .i_rst (i_rst),
        .i_d   (i_pll_locked),
        .o_q   (w_lock_s)
    );

    assign w_tmo_hit    = (r_tmo_cnt == TMO_LAST);
    assign w_stable_hit = w_lock_s && (r_stable_cnt == STABLE_LAST);

    // Nine bits so a MAX_RETRIES of 255 still detects the overflowing attempt.
    assign w_retry_next = {1'b0, r_retry_cnt} + 9'd1;
    assign w_retry_sat  = w_retry_next[8] ? 8'hFF : w_retry_next[7:0];
    assign w_loss_next  = (r_loss_cnt == 8'hFF) ? 8'hFF : r_loss_cnt + 8'd1;

    // Domain i is eligible for release once i*STAGGER_CYCLES cycles have elapsed in RELEASE.
    always_comb begin
        w_rel_mask = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            w_rel_mask[i] = (int'(r_rel_cnt) >= i * STAGGER_CYCLES);
        end
    end

    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_state      <= RESET_PLL;
            r_pll_rst    <= 1'b1;
            r_dom_rst    <= '1;
            r_ready      <= 1'b0;
            r_fault      <= 1'b0;
            r_retry_cnt  <= '0;
            r_loss_cnt   <= '0;
            r_pulse_cnt  <= '0;
            r_stable_cnt <= '0;
            r_tmo_cnt    <= '0;
            r_rel_cnt    <= '0;
        end else if (i_restart_req) begin
            r_state     <= RESET_PLL;
            r_pll_rst   <= 1'b1;
            r_dom_rst   <= '1;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
            r_retry_cnt <= '0;
            r_pulse_cnt <= '0;
        end else begin
            case (r_state)
                RESET_PLL: begin
                    if (r_pulse_cnt == PULSE_LAST) begin
                        r_state      <= WAIT_LOCK;
                        r_pll_rst    <= 1'b0;
                        r_stable_cnt <= '0;
                        r_tmo_cnt    <= '0;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + PULSE_W'(1);
                    end
                end

                WAIT_LOCK: begin
                    if (w_tmo_hit) begin
                        r_retry_cnt <= w_retry_sat;
                        r_pll_rst   <= 1'b1;
                        r_pulse_cnt <= '0;
                        if (w_retry_next > RETRY_LIMIT) begin
                            r_state <= FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_state <= RESET_PLL;
                        end
                    end else if (w_stable_hit) begin
                        r_state   <= RELEASE;
                        r_rel_cnt <= '0;
                    end else begin
                        r_tmo_cnt    <= r_tmo_cnt + TMO_W'(1);
                        r_stable_cnt <= w_lock_s ? r_stable_cnt + STABLE_W'(1) : '0;
                    end
                end

                RELEASE, RUN: begin
                    if (!w_lock_s) begin
                        r_state     <= RESET_PLL;
                        r_pll_rst   <= 1'b1;
                        r_dom_rst   <= '1;
                        r_ready     <= 1'b0;
                        r_pulse_cnt <= '0;
                        r_loss_cnt  <= w_loss_next;
                    end else if (r_state == RELEASE) begin
                        // RUN is entered one cycle after the last domain bit has dropped.
                        if (r_dom_rst == '0) begin
                            r_state     <= RUN;
                            r_ready     <= 1'b1;
                            r_retry_cnt <= '0;
                        end else begin
                            r_dom_rst <= r_dom_rst & ~w_rel_mask;
                            r_rel_cnt <= r_rel_cnt + REL_W'(1);
                        end
                    end
                end

                FAULT: begin
                    r_pll_rst <= 1'b1;
                    r_dom_rst <= '1;
                    r_fault   <= 1'b1;
                end

                default: begin
                    r_state     <= RESET_PLL;
                    r_pll_rst   <= 1'b1;
                    r_dom_rst   <= '1;
                    r_ready     <= 1'b0;
                    r_fault     <= 1'b0;
                    r_pulse_cnt <= '0;
                end
            endcase
        end
    end

    assign o_pll_rst         = r_pll_rst;
    assign o_dom_rst         = r_dom_rst;
    assign o_ready           = r_ready;
    assign o_fault           = r_fault;
    assign o_retry_count     = r_retry_cnt;
    assign o_lock_loss_count = r_loss_cnt;

endmodule
